// File: rtl/mfrsd_spi_bridge_if.sv
// CPU-side bus of the MFRSD SD/SPI bridge: slot/window select, strobes, data and stall.
interface mfrsd_spi_bridge_if;
  logic        cs;
  logic        en;
  logic [15:0] cpu_addr;
  logic [7:0]  din;
  logic        cpu_mreq;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  dout;
  logic        cpu_wait;

  modport slave (
    input  cs, en, cpu_addr, din, cpu_mreq, cpu_rd, cpu_wr,
    output dout, cpu_wait
  );

  modport master (
    output cs, en, cpu_addr, din, cpu_mreq, cpu_rd, cpu_wr,
    input  dout, cpu_wait
  );
endinterface

// File: rtl/mfrsd_spi_bridge.sv
// SD/SPI bridge for MFRSD cartridges: memory-mapped SPI mode-0 master with
// read-ahead data port, divider/status and chip-select registers, CPU stall.
module mfrsd_spi_bridge #(
  parameter int               NUM_CS      = 2,
  parameter int               DIV_W       = 8,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(8'd63)
) (
  input  logic              clk,
  input  logic              reset,
  mfrsd_spi_bridge_if.slave bus,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOW   = 2'd1;
  localparam logic [1:0] ST_HIGH  = 2'd2;

  localparam logic [1:0] CLS_DATA = 2'd0;
  localparam logic [1:0] CLS_DIV  = 2'd1;
  localparam logic [1:0] CLS_CSEL = 2'd2;

  logic [1:0]       state_r;
  logic [7:0]       tx_sr_r;
  logic [7:0]       rx_sr_r;
  logic [7:0]       rx_buf_r;
  logic [7:0]       rd_lat_r;
  logic [2:0]       bitcnt_r;
  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_lat_r;
  logic             prev_rd_r;
  logic             prev_wr_r;
  logic             pend_r;
  logic             pend_wr_r;
  logic [1:0]       pend_cls_r;
  logic [7:0]       pend_data_r;

  logic             win_s;
  logic             rd_s;
  logic             wr_s;
  logic             rd_edge_s;
  logic             wr_edge_s;
  logic             busy_s;
  logic [1:0]       cls_s;
  logic             new_valid_s;
  logic             act_valid_s;
  logic             act_wr_s;
  logic [1:0]       act_cls_s;
  logic [7:0]       act_data_s;
  logic             start_s;
  logic [7:0]       tx_byte_s;
  logic [7:0]       status_s;
  logic [7:0]       dout_s;
  logic             unused_s;

  assign win_s        = bus.cs & bus.en & bus.cpu_mreq & (bus.cpu_addr[15:13] == 3'b010);
  assign rd_s         = win_s & bus.cpu_rd;
  assign wr_s         = win_s & bus.cpu_wr;
  assign rd_edge_s    = rd_s & ~prev_rd_r;
  assign wr_edge_s    = wr_s & ~prev_wr_r;
  assign busy_s       = (state_r != ST_IDLE);
  assign busy         = busy_s;
  assign bus.cpu_wait = pend_r;
  assign status_s     = {busy_s, 7'(spi_cs_n)};
  assign bus.dout     = dout_s;
  assign unused_s     = ^bus.cpu_addr[10:0];

  // Address class decode and selection of the one action executed this cycle
  always_comb begin
    cls_s       = CLS_DATA;
    act_valid_s = 1'b0;
    act_wr_s    = 1'b0;
    act_cls_s   = CLS_DATA;
    act_data_s  = 8'h00;
    tx_byte_s   = 8'hFF;
    if (bus.cpu_addr[12] == 1'b0) begin
      cls_s = CLS_DATA;
    end else if (bus.cpu_addr[11] == 1'b0) begin
      cls_s = CLS_DIV;
    end else begin
      cls_s = CLS_CSEL;
    end
    // STATUS and CSEL reads are side-effect free and never become actions
    new_valid_s = wr_edge_s | (rd_edge_s & (cls_s == CLS_DATA));
    if (busy_s) begin
      act_valid_s = 1'b0;
    end else if (pend_r) begin
      act_valid_s = 1'b1;
      act_wr_s    = pend_wr_r;
      act_cls_s   = pend_cls_r;
      act_data_s  = pend_data_r;
    end else begin
      act_valid_s = new_valid_s;
      act_wr_s    = wr_edge_s;
      act_cls_s   = cls_s;
      act_data_s  = bus.din;
    end
    start_s = act_valid_s & (act_cls_s == CLS_DATA);
    if (act_wr_s) begin
      tx_byte_s = act_data_s;
    end else begin
      tx_byte_s = 8'hFF;
    end
  end

  // CPU read data mux
  always_comb begin
    dout_s = 8'hFF;
    if (rd_s) begin
      case (cls_s)
        CLS_DATA: dout_s = rd_lat_r;
        CLS_DIV:  dout_s = status_s;
        default:  dout_s = 8'hFF;
      endcase
    end else begin
      dout_s = 8'hFF;
    end
  end

  // Strobe edge history, pending-access latch and CPU-visible registers
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_rd_r   <= 1'b0;
      prev_wr_r   <= 1'b0;
      pend_r      <= 1'b0;
      pend_wr_r   <= 1'b0;
      pend_cls_r  <= CLS_DATA;
      pend_data_r <= 8'h00;
      div_r       <= DEFAULT_DIV;
      spi_cs_n    <= {NUM_CS{1'b1}};
      rd_lat_r    <= 8'hFF;
    end else begin
      prev_rd_r <= rd_s;
      prev_wr_r <= wr_s;
      if (busy_s) begin
        if (new_valid_s && !pend_r) begin
          pend_r      <= 1'b1;
          pend_wr_r   <= wr_edge_s;
          pend_cls_r  <= cls_s;
          pend_data_r <= bus.din;
        end
      end else if (pend_r) begin
        // The pended action runs now; a fresh access takes its slot
        if (new_valid_s) begin
          pend_wr_r   <= wr_edge_s;
          pend_cls_r  <= cls_s;
          pend_data_r <= bus.din;
        end else begin
          pend_r <= 1'b0;
        end
      end
      if (act_valid_s && act_wr_s && (act_cls_s == CLS_DIV)) begin
        div_r <= act_data_s[DIV_W-1:0];
      end
      if (act_valid_s && act_wr_s && (act_cls_s == CLS_CSEL)) begin
        spi_cs_n <= act_data_s[NUM_CS-1:0];
      end
      if (act_valid_s && !act_wr_s && (act_cls_s == CLS_DATA)) begin
        rd_lat_r <= rx_buf_r;
      end
    end
  end

  // SPI mode-0 shift engine; divider is captured per byte
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      spi_sclk  <= 1'b0;
      spi_mosi  <= 1'b1;
      tx_sr_r   <= 8'hFF;
      rx_sr_r   <= 8'hFF;
      rx_buf_r  <= 8'hFF;
      bitcnt_r  <= 3'd0;
      cnt_r     <= {DIV_W{1'b0}};
      div_lat_r <= DEFAULT_DIV;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            tx_sr_r   <= tx_byte_s;
            spi_mosi  <= tx_byte_s[7];
            bitcnt_r  <= 3'd7;
            cnt_r     <= div_r;
            div_lat_r <= div_r;
            state_r   <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (cnt_r == {DIV_W{1'b0}}) begin
            spi_sclk <= 1'b1;
            rx_sr_r  <= {rx_sr_r[6:0], spi_miso};
            cnt_r    <= div_lat_r;
            state_r  <= ST_HIGH;
          end else begin
            cnt_r <= cnt_r - DIV_W'(1);
          end
        end
        ST_HIGH: begin
          if (cnt_r == {DIV_W{1'b0}}) begin
            spi_sclk <= 1'b0;
            cnt_r    <= div_lat_r;
            if (bitcnt_r == 3'd0) begin
              rx_buf_r <= rx_sr_r;
              spi_mosi <= 1'b1;
              state_r  <= ST_IDLE;
            end else begin
              bitcnt_r <= bitcnt_r - 3'd1;
              tx_sr_r  <= {tx_sr_r[6:0], 1'b1};
              spi_mosi <= tx_sr_r[6];
              state_r  <= ST_LOW;
            end
          end else begin
            cnt_r <= cnt_r - DIV_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
